// File: rtl/fcmp_pkg.sv
// Shared FloPoCo 34-bit float definitions (wE=8, wF=23) for the comparator arbiter.
// Format: {exc[1:0], sign, exponent[7:0], fraction[22:0]}.
package fcmp_pkg;

  localparam int unsigned FP_W = 34;

  localparam logic [1:0] EXC_ZERO   = 2'b00;
  localparam logic [1:0] EXC_NORMAL = 2'b01;
  localparam logic [1:0] EXC_INF    = 2'b10;
  localparam logic [1:0] EXC_NAN    = 2'b11;

  typedef logic [FP_W-1:0] fp34_t;

  typedef struct packed {
    logic [1:0]  exc;
    logic        sign;
    logic [30:0] expfrac;
  } fp34_s;

  // Unsigned magnitude rank: zero < every normal < inf. The normal flag keeps exponent 0 above zero.
  function automatic logic [32:0] fp_mag(input fp34_s v);
    fp_mag = {v.exc == EXC_INF, v.exc == EXC_NORMAL,
              (v.exc == EXC_NORMAL) ? v.expfrac : 31'd0};
  endfunction

  // A signed zero is treated as non-negative so +0 == -0.
  function automatic logic fp_neg(input fp34_s v);
    fp_neg = v.sign && (v.exc != EXC_ZERO);
  endfunction

endpackage

// File: rtl/fcmplt.sv
// Combinational FloPoCo less-than (wE=8, wF=23): xlty = X<Y, unordered when either input is NaN.
module fcmplt
  import fcmp_pkg::*;
#(
  parameter int unsigned ID = 1
) (
  input  logic [FP_W-1:0] x,
  input  logic [FP_W-1:0] y,
  output logic            xlty,
  output logic            unordered
);

  // ID only tags the instance; anything beyond 16 bits is a wiring mistake.
  if (ID > 32'd65535) begin : g_bad_id
    $error("fcmplt: instance ID out of range");
  end

  fp34_s       xs, ys;
  logic [32:0] x_mag, y_mag;
  logic        x_neg, y_neg, lt;

  assign xs    = x;
  assign ys    = y;
  assign x_mag = fp_mag(xs);
  assign y_mag = fp_mag(ys);
  assign x_neg = fp_neg(xs);
  assign y_neg = fp_neg(ys);

  always_comb begin
    lt = 1'b0;
    case ({x_neg, y_neg})
      2'b10:   lt = 1'b1;
      2'b01:   lt = 1'b0;
      2'b00:   lt = x_mag < y_mag;
      default: lt = x_mag > y_mag;
    endcase
  end

  assign unordered = (xs.exc == EXC_NAN) || (ys.exc == EXC_NAN);
  assign xlty      = lt && !unordered;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = $clog2(N > 1 ? N : 2)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx,
  output logic           any
);

  int unsigned pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = (32'(ptr) + k) % N;
      if (!any && req[IDW'(pos)]) begin
        any               = 1'b1;
        grant[IDW'(pos)]  = 1'b1;
        idx               = IDW'(pos);
      end
    end
  end

endmodule

// File: rtl/fcmp_arbiter.sv
// Round-robin sharing of one fcmplt among N valid/ready requesters, registered tagged response.
// Define FCMP_ARB_PIPE_EN to add an operand register stage ahead of the comparator (latency 2).
module fcmp_arbiter
  import fcmp_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = $clog2(N > 1 ? N : 2),
  parameter int unsigned ID  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_valid,
  output logic [N-1:0]      req_ready,
  input  logic [N*FP_W-1:0] req_x,
  input  logic [N*FP_W-1:0] req_y,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic              resp_xlty,
  output logic              resp_unordered
);

  logic [IDW-1:0] ptr_q, ptr_d, grant_idx;
  logic [N-1:0]   grant;
  logic           grant_any, slot_free, in_ready, accept, load;
  fp34_t          x_arr [N];
  fp34_t          y_arr [N];
  fp34_t          sel_x, sel_y, cmp_x, cmp_y;
  logic [IDW-1:0] cmp_id;
  logic           cmp_lt, cmp_un;

  logic           resp_valid_q, resp_xlty_q, resp_unord_q;
  logic [IDW-1:0] resp_id_q;

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign x_arr[g] = req_x[g*FP_W +: FP_W];
    assign y_arr[g] = req_y[g*FP_W +: FP_W];
  end

  rr_arbiter #(
    .N   (N),
    .IDW (IDW)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  assign sel_x     = x_arr[grant_idx];
  assign sel_y     = y_arr[grant_idx];
  assign slot_free = !resp_valid_q || resp_ready;
  assign accept    = grant_any && in_ready && !rst;
  assign req_ready = (in_ready && !rst) ? grant : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (grant_idx == IDW'(N - 1)) ? '0 : grant_idx + IDW'(1);
    end
  end

`ifdef FCMP_ARB_PIPE_EN
  logic           s1_valid_q, s1_advance;
  logic [IDW-1:0] s1_id_q;
  fp34_t          s1_x_q, s1_y_q;

  // s1 can refill in the same cycle it hands its pair to the output register.
  assign s1_advance = s1_valid_q && slot_free;
  assign in_ready   = !s1_valid_q || slot_free;
  assign load       = s1_advance;
  assign cmp_x      = s1_x_q;
  assign cmp_y      = s1_y_q;
  assign cmp_id     = s1_id_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      s1_id_q    <= grant_idx;
      s1_x_q     <= sel_x;
      s1_y_q     <= sel_y;
    end else if (s1_advance) begin
      s1_valid_q <= 1'b0;
    end
  end
`else
  assign in_ready = slot_free;
  assign load     = accept;
  assign cmp_x    = sel_x;
  assign cmp_y    = sel_y;
  assign cmp_id   = grant_idx;
`endif

  fcmplt #(
    .ID (ID)
  ) u_cmp (
    .x         (cmp_x),
    .y         (cmp_y),
    .xlty      (cmp_lt),
    .unordered (cmp_un)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_xlty_q  <= 1'b0;
      resp_unord_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      if (load) begin
        resp_valid_q <= 1'b1;
        resp_id_q    <= cmp_id;
        resp_xlty_q  <= cmp_lt;
        resp_unord_q <= cmp_un;
      end else if (resp_ready) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

  assign resp_valid     = resp_valid_q;
  assign resp_id        = resp_id_q;
  assign resp_xlty      = resp_xlty_q;
  assign resp_unordered = resp_unord_q;

endmodule

// File: tb/tb_fcmp_arbiter.sv
// Directed bench for fcmp_arbiter: cycle model of arbitration plus a scoreboard of expected responses.
module tb_fcmp_arbiter;
  import fcmp_pkg::*;

  localparam int N   = 4;
  localparam int IDW = 2;
`ifdef FCMP_ARB_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  localparam logic [33:0] P1   = 34'h1_3F80_0000;
  localparam logic [33:0] P2   = 34'h1_4000_0000;
  localparam logic [33:0] M1   = 34'h1_BF80_0000;
  localparam logic [33:0] PZ   = 34'h0_0000_0000;
  localparam logic [33:0] NZ   = 34'h0_8000_0000;
  localparam logic [33:0] PINF = 34'h2_0000_0000;
  localparam logic [33:0] MINF = 34'h2_8000_0000;
  localparam logic [33:0] QNAN = 34'h3_0000_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid, req_ready;
  logic [N*34-1:0]  req_x, req_y;
  logic             resp_valid, resp_ready;
  logic [IDW-1:0]   resp_id;
  logic             resp_xlty, resp_unordered;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           xlty;
    logic           unord;
  } exp_t;

  exp_t        exp_q[$];
  int          seq_ids[$];
  logic [33:0] opx [N];
  logic [33:0] opy [N];
  logic [33:0] table_v [8];
  int          passed = 0;
  int          total  = 0;
  logic        out_v = 1'b0;
  logic        s1v   = 1'b0;
  int          ptr   = 0;
  bit          keep_valid = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_x[g*34 +: 34] = opx[g];
    assign req_y[g*34 +: 34] = opy[g];
  end

  fcmp_arbiter #(
    .N  (N),
    .ID (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_x          (req_x),
    .req_y          (req_y),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_id        (resp_id),
    .resp_xlty      (resp_xlty),
    .resp_unordered (resp_unordered)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    assert (got === want) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, want);
  endtask

  // Reference value via IEEE double; only called for non-NaN inputs.
  function automatic real fp_val(input logic [33:0] v);
    logic [63:0] b;
    logic [10:0] e;
    e = {3'b000, v[30:23]} + 11'd896;
    case (v[33:32])
      2'b00:   b = {v[31], 63'd0};
      2'b10:   b = {v[31], 11'h7FF, 52'd0};
      default: b = {v[31], e, v[22:0], 29'd0};
    endcase
    return $bitstoreal(b);
  endfunction

  function automatic logic [1:0] ref_cmp(input logic [33:0] x, input logic [33:0] y);
    if (x[33:32] == 2'b11 || y[33:32] == 2'b11) return 2'b01;
    return {fp_val(x) < fp_val(y), 1'b0};
  endfunction

  // Called at a falling edge: check just before the rising edge, update model, return at next fall.
  task automatic tick();
    logic         slot_free, can_acc, found, acc, nxt_out;
    int           g;
    logic [N-1:0] exp_ready;
    exp_t         e;
    logic [1:0]   r;
    #4;
    slot_free = !out_v || resp_ready;
    can_acc   = PIPE ? (!s1v || slot_free) : slot_free;
    found     = 1'b0;
    g         = 0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_valid[IDW'((ptr + k) % N)]) begin
        found = 1'b1;
        g     = (ptr + k) % N;
      end
    end
    acc       = found && can_acc;
    exp_ready = acc ? (4'(1) << g) : '0;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("resp_valid", 64'(resp_valid), 64'(out_v));
    if (out_v && exp_q.size() != 0) begin
      e = exp_q[0];
      check("resp_id", 64'(resp_id), 64'(e.id));
      check("resp_xlty", 64'(resp_xlty), 64'(e.xlty));
      check("resp_unordered", 64'(resp_unordered), 64'(e.unord));
    end
    @(posedge clk);
    if (out_v && resp_ready && exp_q.size() != 0) begin
      seq_ids.push_back(int'(exp_q[0].id));
      void'(exp_q.pop_front());
    end
    if (acc) begin
      r = ref_cmp(opx[g], opy[g]);
      exp_q.push_back({IDW'(g), r});
      ptr = (g + 1) % N;
    end
    if (PIPE) begin
      nxt_out = (s1v && slot_free) || (out_v && !resp_ready);
      s1v     = acc || (s1v && !slot_free);
    end else begin
      nxt_out = acc || (out_v && !resp_ready);
    end
    out_v = nxt_out;
    @(negedge clk);
    if (acc) begin
      if (keep_valid) begin
        opx[g] = table_v[$urandom_range(0, 7)];
        opy[g] = table_v[$urandom_range(0, 7)];
      end else begin
        req_valid[IDW'(g)] = 1'b0;
      end
    end
  endtask

  // Called at a falling edge; reset is visible on the outputs without waiting for a clock.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_id", 64'(resp_id), 64'd0);
    check("rst_resp_xlty", 64'(resp_xlty), 64'd0);
    check("rst_resp_unordered", 64'(resp_unordered), 64'd0);
    exp_q.delete();
    out_v = 1'b0;
    s1v   = 1'b0;
    ptr   = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    table_v = '{P1, P2, M1, PZ, NZ, PINF, MINF, QNAN};
    for (int i = 0; i < N; i++) begin
      opx[i] = PZ;
      opy[i] = PZ;
    end
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 4'hF;  // requests during reset must not be granted
    do_reset();
    req_valid = '0;

    // single request, +1.0 < +2.0
    resp_ready = 1'b1;
    opx[0] = P1;
    opy[0] = P2;
    req_valid[0] = 1'b1;
    repeat (4) tick();

    // all requesters streaming, resp_ready high
    req_valid = '0;
    do_reset();
    seq_ids.delete();
    for (int i = 0; i < N; i++) begin
      opx[i] = table_v[i];
      opy[i] = table_v[7 - i];
    end
    keep_valid = 1'b1;
    req_valid  = 4'hF;
    repeat (12) tick();
    keep_valid = 1'b0;
    req_valid  = '0;
    repeat (3) tick();
    check("stream_count", 64'(seq_ids.size()), 64'd12);
    for (int k = 0; k < seq_ids.size(); k++) check("stream_order", 64'(seq_ids[k]), 64'(k % 4));

    // back-pressure: response must hold while resp_ready is low
    resp_ready = 1'b0;
    opx[1] = M1;
    opy[1] = PZ;
    opx[3] = P2;
    opy[3] = M1;
    req_valid = 4'b1010;
    repeat (6) tick();
    check("held_id", 64'(resp_id), 64'd1);
    check("held_xlty", 64'(resp_xlty), 64'd1);
    resp_ready = 1'b1;
    repeat (4) tick();

    // comparator corner cases through requester 2
    begin
      logic [33:0] xs [10];
      logic [33:0] ys [10];
      xs = '{QNAN, P2, MINF, NZ, PZ, M1, PINF, P1,   M1,   MINF};
      ys = '{P1,   P1, M1,   PZ, NZ, PZ, PINF, QNAN, MINF, PINF};
      for (int i = 0; i < 10; i++) begin
        opx[2] = xs[i];
        opy[2] = ys[i];
        req_valid[2] = 1'b1;
        repeat (3) tick();
      end
    end

    // async reset right after an accept discards the result; pointer restarts at 0
    opx[2] = P1;
    opy[2] = P2;
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b1010;
    do_reset();
    repeat (5) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
